// File: rtl/gv_input_pkg.sv
// gv_input_pkg: shared widths and the event record for the lane input arbiter.
package gv_input_pkg;
  localparam int NLANES_DEF = 4;
  localparam int STAMP_W = 8;
  typedef struct packed {
    logic [2:0] lane;
    logic [STAMP_W-1:0] stamp;
  } ev_t;
endpackage

// File: rtl/lane_capture.sv
// lane_capture: one button lane: synchronizer, rising-edge detect, lockout,
// pending/stamp hold and sticky overrun flag.
module lane_capture
  import gv_input_pkg::*;
#(
  parameter int LOCKOUT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn,
  input  logic en,
  input  logic grant,
  input  logic clr_ovr,
  input  logic [STAMP_W-1:0] stamp,
  output logic pending,
  output logic [STAMP_W-1:0] stamp_held,
  output logic overrun
);
  localparam int CW = $clog2(LOCKOUT + 1);
  logic [2:0] sync_q, sync_d;
  logic locked_q, locked_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic ovr_q, ovr_d;
  logic accept, take, last;
  always_comb begin
    sync_d = {sync_q[1:0], btn};
    accept = sync_q[1] & ~sync_q[2] & en & ~locked_q;
    last = cnt_q == CW'(LOCKOUT - 1);
    locked_d = accept | (locked_q & ~last);
    cnt_d = (accept || !locked_q || last) ? '0 : cnt_q + 1'b1;
    // a grant frees the slot this cycle, so a coincident press re-arms it
    take = accept & (~pend_q | grant);
    pend_d = take | (pend_q & ~grant);
    stamp_d = take ? stamp : stamp_q;
    ovr_d = (accept & pend_q & ~grant) | (ovr_q & ~clr_ovr);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      locked_q <= 1'b0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      stamp_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      locked_q <= locked_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      stamp_q <= stamp_d;
      ovr_q <= ovr_d;
    end
  end
  assign pending = pend_q;
  assign stamp_held = stamp_q;
  assign overrun = ovr_q;
endmodule

// File: rtl/input_arbiter.sv
// input_arbiter: timestamps lane presses, round-robin arbitrates pending lanes
// into a small event FIFO.
module input_arbiter
  import gv_input_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int LOCKOUT = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic [NLANES-1:0] buttons,
  input  logic en,
  input  logic beat_tick,
  input  logic ev_ready,
  input  logic clr_ovr,
  output logic ev_valid,
  output logic [$clog2(NLANES)-1:0] ev_lane,
  output logic [STAMP_W-1:0] ev_stamp,
  output logic [NLANES-1:0] overrun
);
  localparam int LW = $clog2(NLANES);
  localparam int PW = $clog2(DEPTH);
  logic [NLANES-1:0] pending, grant_v;
  logic [STAMP_W-1:0] held [NLANES];
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [LW-1:0] ptr_q, ptr_d, sel;
  logic [LW:0] idx;
  logic found, push, pop;
  ev_t mem_q [DEPTH];
  ev_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    lane_capture #(.LOCKOUT(LOCKOUT)) u_lane (
      .clk(clk), .n_rst(n_rst), .btn(buttons[g]), .en(en), .grant(grant_v[g]),
      .clr_ovr(clr_ovr), .stamp(stamp_q), .pending(pending[g]),
      .stamp_held(held[g]), .overrun(overrun[g])
    );
  end
  assign ev_valid = cnt_q != '0;
  assign pop = ev_valid & ev_ready;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < NLANES; k++) begin
      idx = {1'b0, ptr_q} + (LW+1)'(k);
      if (idx >= (LW+1)'(NLANES)) idx = idx - (LW+1)'(NLANES);
      if (!found && pending[idx[LW-1:0]]) begin
        found = 1'b1;
        sel = idx[LW-1:0];
      end
    end
    // fullness is judged on the registered count, so a pop never makes room the same cycle
    push = found & (cnt_q < (PW+1)'(DEPTH));
    grant_v = push ? (NLANES'(1) << sel) : '0;
    ptr_d = push ? ((sel == LW'(NLANES - 1)) ? '0 : sel + 1'b1) : ptr_q;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = '{lane: 3'(sel), stamp: held[sel]};
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    stamp_d = stamp_q + STAMP_W'(beat_tick);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stamp_q <= '0;
      ptr_q <= '0;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      stamp_q <= stamp_d;
      ptr_q <= ptr_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign ev_lane = LW'(mem_q[rd_q].lane);
  assign ev_stamp = mem_q[rd_q].stamp;
endmodule
